// File: rtl/framing_pkg.sv
// Shared types and default framing constants for the packet arbiter slice.
package framing_pkg;

    typedef enum logic {
        idle_s   = 1'b0,
        locked_s = 1'b1
    } arb_state_e;

    localparam logic [7:0] tail_byte_0_c = 8'h0D;
    localparam logic [7:0] tail_byte_1_c = 8'h0A;
    localparam int         packet_len_c  = 1024;

    // A single requester still needs a one-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: searches upward from last+1, wrapping at num_req_p.
module rr_arbiter
    import framing_pkg::*;
#(
    parameter int num_req_p = 2,
    parameter int idx_w_p   = idx_width(num_req_p)
) (
    input  logic [num_req_p-1:0] req,
    input  logic [idx_w_p-1:0]   last,
    output logic [num_req_p-1:0] grant,
    output logic [idx_w_p-1:0]   idx,
    output logic                 any
);

    int                 sum;
    logic [idx_w_p-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        sum   = 0;
        cand  = '0;
        for (int k = 1; k <= num_req_p; k++) begin
            sum = int'(last) + k;
            if (sum >= num_req_p) begin
                sum = sum - num_req_p;
            end
            cand = idx_w_p'(sum);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/packet_arbiter.sv
// Packet-locked round-robin arbiter: one owner streams payload plus two tail beats,
// released purely by beat count; tail mismatches raise a one-cycle frame error.
module packet_arbiter
    import framing_pkg::*;
#(
    parameter int                 num_req_p          = 2,
    parameter int                 width_p            = 8,
    parameter int                 packet_len_elems_p = packet_len_c,
    parameter logic [width_p-1:0] tail_byte_0_p      = tail_byte_0_c,
    parameter logic [width_p-1:0] tail_byte_1_p      = tail_byte_1_c
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic [num_req_p-1:0]         valid_i,
    output logic [num_req_p-1:0]         ready_o,
    input  logic [num_req_p*width_p-1:0] data_i,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [width_p-1:0]           data_o,
    output logic [num_req_p-1:0]         grant_o,
    output logic                         frame_err_o
);

    localparam int idx_w_c = idx_width(num_req_p);
    localparam int cnt_w_c = $clog2(packet_len_elems_p + 2);

    localparam logic [cnt_w_c-1:0] tail0_beat_c = cnt_w_c'(packet_len_elems_p);
    localparam logic [cnt_w_c-1:0] tail1_beat_c = cnt_w_c'(packet_len_elems_p + 1);
    localparam logic [idx_w_c-1:0] last_init_c  = idx_w_c'(num_req_p - 1);

    arb_state_e           state_r;
    logic [idx_w_c-1:0]   owner_r;
    logic [idx_w_c-1:0]   last_r;
    logic [num_req_p-1:0] grant_r;
    logic [cnt_w_c-1:0]   beat_cnt_r;
    logic                 frame_err_r;

    logic [num_req_p-1:0] pick_grant;
    logic [idx_w_c-1:0]   pick_idx;
    logic                 pick_any;

    logic [width_p-1:0]   data_arr [num_req_p];
    logic                 owner_valid;
    logic [width_p-1:0]   owner_data;
    logic                 fire;
    logic                 tail_bad;

    rr_arbiter #(
        .num_req_p (num_req_p),
        .idx_w_p   (idx_w_c)
    ) u_rr_arbiter (
        .req   (valid_i),
        .last  (last_r),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    for (genvar r = 0; r < num_req_p; r++) begin : g_unpack
        assign data_arr[r] = data_i[r*width_p +: width_p];
    end

    always_comb begin
        owner_valid = valid_i[owner_r];
        owner_data  = data_arr[owner_r];
        fire        = (state_r == locked_s) && owner_valid && ready_i;
        tail_bad    = ((beat_cnt_r == tail0_beat_c) && (owner_data != tail_byte_0_p)) ||
                      ((beat_cnt_r == tail1_beat_c) && (owner_data != tail_byte_1_p));
    end

    // The owner's stream is passed straight through so a stalled upstream stalls the packet.
    always_comb begin
        valid_o = 1'b0;
        data_o  = '0;
        ready_o = '0;
        grant_o = '0;
        if (state_r == locked_s) begin
            valid_o = owner_valid;
            data_o  = owner_data;
            ready_o = grant_r & {num_req_p{ready_i}};
            grant_o = grant_r;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r     <= idle_s;
            owner_r     <= '0;
            last_r      <= last_init_c;
            grant_r     <= '0;
            beat_cnt_r  <= '0;
            frame_err_r <= 1'b0;
        end else begin
            frame_err_r <= fire && tail_bad;
            case (state_r)
                idle_s: begin
                    if (pick_any) begin
                        state_r    <= locked_s;
                        owner_r    <= pick_idx;
                        grant_r    <= pick_grant;
                        beat_cnt_r <= '0;
                    end
                end
                locked_s: begin
                    // Release depends only on the count; tail-valued payload never ends a packet.
                    if (fire) begin
                        if (beat_cnt_r == tail1_beat_c) begin
                            state_r    <= idle_s;
                            last_r     <= owner_r;
                            grant_r    <= '0;
                            beat_cnt_r <= '0;
                        end else begin
                            beat_cnt_r <= beat_cnt_r + cnt_w_c'(1);
                        end
                    end
                end
                default: state_r <= idle_s;
            endcase
        end
    end

    assign frame_err_o = frame_err_r;

endmodule

// File: tb/tb_packet_arbiter.sv
// Scoreboard bench for packet_arbiter with four payload beats per packet.
module tb_packet_arbiter;

    typedef struct {
        logic [7:0] data;
        logic [1:0] grant;
        logic       err_after;
    } beat_t;

    typedef struct {
        int         req;
        logic [7:0] beats [6];
        logic [1:0] grant_exp;
        logic [1:0] err_exp;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic [1:0]  valid_i;
    logic [1:0]  ready_o;
    logic [15:0] data_i;
    logic        valid_o;
    logic        ready_i;
    logic [7:0]  data_o;
    logic [1:0]  grant_o;
    logic        frame_err_o;

    int compared   = 0;
    int mismatched = 0;
    int cycle      = 0;
    int fire_count = 0;
    int gap_left   = 0;

    beat_t      exp_q [$];
    logic [7:0] src0_q [$];
    logic [7:0] src1_q [$];
    int         fire_cycles [$];
    logic       pend_err    = 1'b0;
    bit         toggle_mode = 1'b0;
    logic       toggle_bit  = 1'b0;
    bit         hold_check  = 1'b0;

    packet_arbiter #(
        .num_req_p          (2),
        .width_p            (8),
        .packet_len_elems_p (4),
        .tail_byte_0_p      (8'h0D),
        .tail_byte_1_p      (8'h0A)
    ) dut (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .data_i      (data_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .data_o      (data_o),
        .grant_o     (grant_o),
        .frame_err_o (frame_err_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic driveInputs();
        valid_i[0]   = (src0_q.size() > 0) && (gap_left == 0);
        valid_i[1]   = (src1_q.size() > 0);
        data_i[7:0]  = (src0_q.size() > 0) ? src0_q[0] : 8'h00;
        data_i[15:8] = (src1_q.size() > 0) ? src1_q[0] : 8'h00;
        ready_i      = toggle_mode ? toggle_bit : 1'b1;
    endtask

    // One clock: sample upstream handshakes at the falling edge, advance sources after the rising edge.
    task automatic tick();
        logic [1:0] up_fire;
        @(negedge clk_i);
        up_fire = valid_i & ready_o;
        if (hold_check && grant_o == 2'b01) checkOutput("hold_off_r1", ready_o[1], 0);
        @(posedge clk_i);
        #1;
        if (up_fire[0]) void'(src0_q.pop_front());
        if (up_fire[1]) void'(src1_q.pop_front());
        if (gap_left > 0) gap_left--;
        toggle_bit = ~toggle_bit;
        driveInputs();
    endtask

    task automatic applyStimulus(input int req, input logic [7:0] beats [6],
                                 input logic [1:0] grant_exp, input logic [1:0] err_exp);
        beat_t rec;
        for (int i = 0; i < 6; i++) begin
            if (req == 0) src0_q.push_back(beats[i]);
            else          src1_q.push_back(beats[i]);
            rec.data      = beats[i];
            rec.grant     = grant_exp;
            rec.err_after = (i == 4) ? err_exp[0] : ((i == 5) ? err_exp[1] : 1'b0);
            exp_q.push_back(rec);
        end
        driveInputs();
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 300) begin
            tick();
            n++;
        end
        checkOutput({name, "_drained"}, exp_q.size(), 0);
        if (exp_q.size() > 0) begin
            exp_q.delete();
            src0_q.delete();
            src1_q.delete();
            driveInputs();
        end
        tick();
        tick();
    endtask

    // Output monitor: every downstream fire pops one expected beat; frame error checked every cycle.
    initial begin
        beat_t rec;
        forever begin
            @(negedge clk_i);
            if (reset_n_i !== 1'b1) begin
                pend_err = 1'b0;
            end else begin
                checkOutput("frame_err", frame_err_o, pend_err);
                pend_err = 1'b0;
                if (valid_o && ready_i) begin
                    fire_count++;
                    fire_cycles.push_back(cycle);
                    if (exp_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("[TB] FAIL unexpected_beat: got data 0x%0h grant 0x%0h, expected no beat", data_o, grant_o);
                    end else begin
                        rec = exp_q.pop_front();
                        checkOutput("beat_data", data_o, rec.data);
                        checkOutput("beat_grant", grant_o, rec.grant);
                        pend_err = rec.err_after;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t       vecs [5];
        logic [7:0] pa [6];
        logic [7:0] pb [6];
        logic [7:0] pc [6];
        int         base;
        int         n;
        bit         gapped;

        reset_n_i = 1'b0;
        valid_i   = '0;
        data_i    = '0;
        ready_i   = 1'b0;

        pa = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h0D, 8'h0A};
        pb = '{8'h81, 8'h82, 8'h83, 8'h84, 8'h0D, 8'h0A};
        pc = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'h0D, 8'h0A};

        vecs[0].req = 0; vecs[0].beats = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h0D, 8'h0A};
        vecs[0].grant_exp = 2'b01; vecs[0].err_exp = 2'b00;
        vecs[1].req = 0; vecs[1].beats = '{8'h0D, 8'h0A, 8'h0D, 8'h0A, 8'h0D, 8'h0A};
        vecs[1].grant_exp = 2'b01; vecs[1].err_exp = 2'b00;
        vecs[2].req = 0; vecs[2].beats = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h0D, 8'hFF};
        vecs[2].grant_exp = 2'b01; vecs[2].err_exp = 2'b10;
        vecs[3].req = 1; vecs[3].beats = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h0D, 8'h0A};
        vecs[3].grant_exp = 2'b10; vecs[3].err_exp = 2'b00;
        vecs[4].req = 1; vecs[4].beats = '{8'h55, 8'h66, 8'h77, 8'h88, 8'hEE, 8'h0A};
        vecs[4].grant_exp = 2'b10; vecs[4].err_exp = 2'b01;

        repeat (3) tick();
        checkOutput("rst_valid_o", valid_o, 0);
        checkOutput("rst_ready_o", ready_o, 0);
        checkOutput("rst_grant_o", grant_o, 0);
        checkOutput("rst_data_o", data_o, 0);
        checkOutput("rst_frame_err_o", frame_err_o, 0);

        // Both requesters valid out of reset: req0 first, then req1 after one idle cycle.
        applyStimulus(0, pa, 2'b01, 2'b00);
        applyStimulus(1, pb, 2'b10, 2'b00);
        fire_cycles.delete();
        tick();
        reset_n_i = 1'b1;
        drain("contend_a");
        if (fire_cycles.size() >= 7) checkOutput("idle_gap_a", fire_cycles[6] - fire_cycles[5], 2);
        else                         checkOutput("fires_a", fire_cycles.size(), 12);

        applyStimulus(0, pa, 2'b01, 2'b00);
        applyStimulus(1, pb, 2'b10, 2'b00);
        drain("contend_b");

        // Persistent req0 with req1 waiting: grants must alternate.
        applyStimulus(0, pa, 2'b01, 2'b00);
        applyStimulus(1, pb, 2'b10, 2'b00);
        applyStimulus(0, pc, 2'b01, 2'b00);
        fire_cycles.delete();
        drain("rotate");
        if (fire_cycles.size() >= 13) checkOutput("idle_gap_rot", fire_cycles[12] - fire_cycles[11], 2);
        else                          checkOutput("fires_rot", fire_cycles.size(), 18);

        applyStimulus(0, pa, 2'b01, 2'b00);
        applyStimulus(0, pc, 2'b01, 2'b00);
        fire_cycles.delete();
        drain("single_regrant");
        if (fire_cycles.size() >= 7) checkOutput("idle_gap_single", fire_cycles[6] - fire_cycles[5], 2);
        else                         checkOutput("fires_single", fire_cycles.size(), 12);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].req, vecs[i].beats, vecs[i].grant_exp, vecs[i].err_exp);
            drain($sformatf("vec%0d", i));
            checkOutput($sformatf("vec%0d_idle_grant", i), grant_o, 0);
            checkOutput($sformatf("vec%0d_idle_valid", i), valid_o, 0);
        end

        // Toggling downstream ready plus an upstream gap; req1 must stay held off meanwhile.
        toggle_mode = 1'b1;
        hold_check  = 1'b1;
        applyStimulus(0, pa, 2'b01, 2'b00);
        n = 0;
        while (grant_o !== 2'b01 && n < 20) begin
            tick();
            n++;
        end
        checkOutput("b_grant_r0", grant_o, 2'b01);
        applyStimulus(1, pb, 2'b10, 2'b00);
        base   = fire_count;
        gapped = 1'b0;
        n      = 0;
        while (exp_q.size() > 6 && n < 200) begin
            tick();
            n++;
            if (!gapped && (fire_count - base) >= 2) begin
                gap_left = 3;
                gapped   = 1'b1;
                driveInputs();
            end
        end
        drain("b_stream");
        hold_check  = 1'b0;
        toggle_mode = 1'b0;
        driveInputs();

        // Reset in the middle of a packet: outputs drop at once and the rest is abandoned.
        applyStimulus(0, pa, 2'b01, 2'b00);
        base = fire_count;
        n    = 0;
        while ((fire_count - base) < 3 && n < 50) begin
            tick();
            n++;
        end
        checkOutput("c_three_beats", fire_count - base, 3);
        #2;
        reset_n_i = 1'b0;
        #1;
        checkOutput("c_async_valid_o", valid_o, 0);
        checkOutput("c_async_ready_o", ready_o, 0);
        checkOutput("c_async_grant_o", grant_o, 0);
        checkOutput("c_async_data_o", data_o, 0);
        exp_q.delete();
        src0_q.delete();
        src1_q.delete();
        driveInputs();
        tick();
        tick();
        reset_n_i = 1'b1;
        repeat (3) tick();
        applyStimulus(1, pb, 2'b10, 2'b00);
        drain("c_after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
